point_predict_sequencer: RTL

//  Sequences the LiDAR geometry point predictor. Accepts a stream of per-point residuals

---
 rtl/point_predict_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/point_predict_sequencer.sv
// rtl/point_predict_sequencer.sv - history sequencer for the LiDAR geometry point predictor
//
// Purpose: accepts per-point residuals with prediction modes, keeps the two-point
// reconstruction history, drives the external combinational predictor and emits
// reconstructed points (prediction + residual) on a valid/ready stream, one cycle
// after accept. Optional statistics are built when POINT_PRED_STATS_EN is defined.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   flush                   clears history (and statistics) after the current cycle
//   in_valid/in_ready       residual beat handshake
//   in_sof, in_mode, in_res first-of-frame flag, prediction mode, residual {x,y,z}
//   pp_mode                 effective mode to the predictor
//   pp_prev1, pp_prev2      history points n-1 and n-2 to the predictor
//   pp_pred                 predictor result (combinational, same cycle)
//   out_valid/out_ready     reconstructed point handshake
//   out_point, out_sof      reconstructed point {x,y,z} and its frame-start flag
//   stat_pts, stat_demote   accepted-beat and demotion counters (POINT_PRED_STATS_EN only)
module point_predict_sequencer #(
  parameter int COORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [1:0]           in_mode,
  input  logic [3*COORD_W-1:0] in_res,
  output logic [1:0]           pp_mode,
  output logic [3*COORD_W-1:0] pp_prev1,
  output logic [3*COORD_W-1:0] pp_prev2,
  input  logic [3*COORD_W-1:0] pp_pred,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*COORD_W-1:0] out_point,
  output logic                 out_sof
`ifdef POINT_PRED_STATS_EN
  ,
  output logic [31:0]          stat_pts,
  output logic [15:0]          stat_demote
`endif
);

  localparam int PW = 3 * COORD_W;

  typedef enum logic [1:0] {
    H0 = 2'd0,
    H1 = 2'd1,
    H2 = 2'd2
  } hist_t;

  hist_t         hist_st;
  hist_t         hist_nx;
  logic [PW-1:0] prev1;
  logic [PW-1:0] prev2;
  logic [PW-1:0] recon;
  logic [1:0]    em;
  logic          accept;
  logic          demote;

  // The output register is the only buffer: a new beat may enter whenever the
  // held beat is leaving (or there is none).
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign pp_mode  = em;
  assign pp_prev1 = prev1;
  assign pp_prev2 = prev2;

  // History state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_st <= H0;
    end else begin
      hist_st <= hist_nx;
    end
  end

  // Effective mode and next history state. Linear extrapolation needs two
  // points, so with only one point it falls back to "previous".
  always_comb begin
    em      = in_mode;
    demote  = 1'b0;
    hist_nx = hist_st;
    if (hist_st == H0 || in_sof) begin
      em = 2'b10;
    end else if (hist_st == H1 && in_mode == 2'b01) begin
      em     = 2'b00;
      demote = accept;
    end
    if (flush) begin
      hist_nx = H0;
    end else if (accept) begin
      if (in_sof || hist_st == H0) begin
        hist_nx = H1;
      end else begin
        hist_nx = H2;
      end
    end
  end

  // Per-coordinate modular addition; carries never cross coordinate boundaries.
  always_comb begin
    recon = '0;
    for (int c = 0; c < 3; c++) begin
      recon[c*COORD_W +: COORD_W] = pp_pred[c*COORD_W +: COORD_W] + in_res[c*COORD_W +: COORD_W];
    end
  end

  // Output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_point <= '0;
      out_sof   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_point <= recon;
      out_sof   <= in_sof;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // History registers; flush wins over a same-cycle accept, but that accepted
  // beat has already been reconstructed from the old history above.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev1 <= '0;
      prev2 <= '0;
    end else if (flush) begin
      prev1 <= '0;
      prev2 <= '0;
    end else if (accept) begin
      prev1 <= recon;
      prev2 <= in_sof ? '0 : prev1;
    end
  end

`ifdef POINT_PRED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      stat_pts    <= '0;
      stat_demote <= '0;
    end else if (accept) begin
      stat_pts <= in_sof ? 32'd1 : stat_pts + 32'd1;
      if (demote && stat_demote != 16'hFFFF) begin
        stat_demote <= stat_demote + 16'd1;
      end
    end
  end
`endif

endmodule
